// File: rtl/cmp_pkg.sv
// Shared constants and types for the serial magnitude comparator.
package cmp_pkg;

    localparam int unsigned PAIR_W = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CMP  = ST_CMP,
        DONE = ST_DONE
    } state_t;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } flags_t;

endpackage

// File: rtl/two_bitcomp.sv
// Combinational magnitude compare of two unsigned 2-bit values.
module two_bitcomp
    import cmp_pkg::*;
(
    input  logic [PAIR_W-1:0] a,
    input  logic [PAIR_W-1:0] b,
    output logic              gt,
    output logic              lt,
    output logic              eq
);

    logic msb_eq;

    // Lower bit only matters when the upper bits tie.
    always_comb begin
        msb_eq = ~(a[1] ^ b[1]);
        gt     = (a[1] & ~b[1]) | (msb_eq & a[0] & ~b[0]);
        lt     = (~a[1] & b[1]) | (msb_eq & ~a[0] & b[0]);
        eq     = (a == b);
    end

endmodule

// File: rtl/serial_mag_comp.sv
// Unsigned magnitude comparator that walks the operands two bits per cycle,
// MSB pair first, stopping at the first differing pair.
module serial_mag_comp
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             A_gt_B,
    output logic             A_lt_B,
    output logic             A_eq_B
);

    localparam int unsigned NPAIRS = WIDTH / PAIR_W;
    localparam int unsigned IDX_W  = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(NPAIRS - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = '0;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    flags_t             flags_q;
    logic               busy_q;
    logic               done_q;

    logic [PAIR_W-1:0]  a_pair;
    logic [PAIR_W-1:0]  b_pair;
    logic               pair_gt;
    logic               pair_lt;
    logic               pair_eq;

    // Select the pair currently under inspection.
    always_comb begin
        a_pair = a_q[int'(idx) * PAIR_W +: PAIR_W];
        b_pair = b_q[int'(idx) * PAIR_W +: PAIR_W];
    end

    two_bitcomp u_pair_cmp (
        .a  (a_pair),
        .b  (b_pair),
        .gt (pair_gt),
        .lt (pair_lt),
        .eq (pair_eq)
    );

    // Sequencer: capture, walk pairs, publish result for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            flags_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        idx    <= IDX_MSB;
                        state  <= CMP;
                        busy_q <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                CMP: begin
                    if (!pair_eq) begin
                        flags_q <= '{gt: pair_gt, lt: pair_lt, eq: 1'b0};
                        state   <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (idx == IDX_ZERO) begin
                        flags_q <= '{gt: 1'b0, lt: 1'b0, eq: 1'b1};
                        state   <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign A_gt_B = flags_q.gt;
    assign A_lt_B = flags_q.lt;
    assign A_eq_B = flags_q.eq;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Directed-vector bench for serial_mag_comp at WIDTH=8.
module tb_serial_mag_comp;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic       A_gt_B;
    logic       A_lt_B;
    logic       A_eq_B;

    int total = 0;
    int bad   = 0;

    serial_mag_comp #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .A_gt_B (A_gt_B),
        .A_lt_B (A_lt_B),
        .A_eq_B (A_eq_B)
    );

    always #5 clk = ~clk;

    // Outputs packed as {busy, done, gt, lt, eq}.
    function automatic logic [4:0] outs();
        return {busy, done, A_gt_B, A_lt_B, A_eq_B};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'h00;
        tick(); tick();
        total++;
        if (outs() !== 5'b00000) begin
            bad++;
            $display("FAIL reset_state: got %b want %b", outs(), 5'b00000);
        end
        start = 1'b0;
        rst   = 1'b0;
        tick();
        total++;
        if (outs() !== 5'b00000) begin
            bad++;
            $display("FAIL idle_after_reset: got %b want %b", outs(), 5'b00000);
        end
    endtask

    // Launch one compare and check edge count plus final flags.
    task automatic run_op(input string name, input logic [7:0] av, input logic [7:0] bv,
                          input int exp_k, input logic [2:0] exp_flags);
        int n;
        a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL %s_busy: got %b want 1", name, busy);
        end
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (n !== exp_k) begin
            bad++;
            $display("FAIL %s_edges: got %0d want %0d", name, n, exp_k);
        end
        total++;
        if (outs() !== {2'b01, exp_flags}) begin
            bad++;
            $display("FAIL %s_result: got %b want %b", name, outs(), {2'b01, exp_flags});
        end
        tick();
        total++;
        if (outs() !== {2'b00, exp_flags}) begin
            bad++;
            $display("FAIL %s_after: got %b want %b", name, outs(), {2'b00, exp_flags});
        end
    endtask

    task automatic test_equal();
        run_op("eq_a5", 8'hA5, 8'hA5, 4, 3'b001);
    endtask

    task automatic test_gt_first_pair();
        run_op("gt_80_7f", 8'h80, 8'h7F, 1, 3'b100);
    endtask

    task automatic test_lt_last_pair();
        run_op("lt_12_13", 8'h12, 8'h13, 4, 3'b010);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (outs() !== 5'b00010) begin
                bad++;
                $display("FAIL lt_hold_%0d: got %b want %b", i, outs(), 5'b00010);
            end
        end
    endtask

    // Captured 0x41 vs 0x40 is gt on the last pair; 0x00 vs 0xFF would be lt on the first.
    task automatic test_ignore_while_busy();
        int n;
        a = 8'h41; b = 8'h40; start = 1'b1;
        tick();
        a = 8'h00; b = 8'hFF;
        tick(); tick();
        total++;
        if (outs() !== 5'b10010) begin
            bad++;
            $display("FAIL ign_mid: got %b want %b", outs(), 5'b10010);
        end
        start = 1'b0;
        n = 2;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (n !== 4) begin
            bad++;
            $display("FAIL ign_edges: got %0d want 4", n);
        end
        total++;
        if (outs() !== 5'b01100) begin
            bad++;
            $display("FAIL ign_result: got %b want %b", outs(), 5'b01100);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int seen_done;
        a = 8'h00; b = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        total++;
        if (outs() !== 5'b00000) begin
            bad++;
            $display("FAIL abort_state: got %b want %b", outs(), 5'b00000);
        end
        seen_done = 0;
        for (int i = 0; i < 5; i++) begin
            if (done === 1'b1) seen_done++;
            tick();
        end
        total++;
        if (seen_done !== 0) begin
            bad++;
            $display("FAIL abort_no_done: got %0d pulses want 0", seen_done);
        end
        // Start on the very first edge with reset released.
        rst = 1'b0; start = 1'b1; a = 8'h80; b = 8'h7F;
        tick();
        start = 1'b0;
        total++;
        if (outs() !== 5'b10000) begin
            bad++;
            $display("FAIL first_edge_start: got %b want %b", outs(), 5'b10000);
        end
        tick();
        total++;
        if (outs() !== 5'b01100) begin
            bad++;
            $display("FAIL first_edge_result: got %b want %b", outs(), 5'b01100);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        a = 8'hC0; b = 8'h40; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        total++;
        if (outs() !== 5'b01100) begin
            bad++;
            $display("FAIL b2b_first: got %b want %b", outs(), 5'b01100);
        end
        a = 8'h01; b = 8'h02; start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (outs() !== 5'b10100) begin
            bad++;
            $display("FAIL b2b_reenter: got %b want %b", outs(), 5'b10100);
        end
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (n !== 4) begin
            bad++;
            $display("FAIL b2b_edges: got %0d want 4", n);
        end
        total++;
        if (outs() !== 5'b01010) begin
            bad++;
            $display("FAIL b2b_second: got %b want %b", outs(), 5'b01010);
        end
        tick();
        total++;
        if (outs() !== 5'b00010) begin
            bad++;
            $display("FAIL b2b_idle: got %b want %b", outs(), 5'b00010);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        test_reset();
        test_equal();
        test_gt_first_pair();
        test_lt_last_pair();
        test_ignore_while_busy();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
